gcm_mem_arbiter: RTL and testbench

- Upstream storage and handoff stage for the GCM datapath top.
- Holds the 64x16 word buffer that the core reads plaintext/ciphertext from (q) and writes results into (d).
- Arbitrates that buffer between the ARM host bus and the core.
- Generates the done_arm/done_arm2 start handshakes and captures the final MAC for the host.

---
 rtl/gcm_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_gcm_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_mem_arbiter.sv
// gcm_mem_arbiter: word buffer shared between the ARM host bus and the GCM core.
// The host owns the buffer in S_HOST. Starting a phase hands the buffer to the core
// and holds done_arm/done_arm2 as a level until the core answers. Any phase that
// stalls for TIMEOUT cycles is aborted, and the final MAC is captured for the host.
module gcm_mem_arbiter #(
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    // host bus
    input  logic          h_sel,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    input  logic          h_start,
    input  logic          h_start2,
    // core side
    input  logic          en_memory,
    input  logic          en_r,
    input  logic          en_w,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    input  logic          done,
    input  logic          done2,
    input  logic [DW-1:0] MAC,
    output logic          done_arm,
    output logic          done_arm2,
    output logic          busy,
    output logic [DW-1:0] mac_q,
    output logic          err
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_HOST  = 3'd0,
        S_ARM1  = 3'd1,
        S_CORE1 = 3'd2,
        S_ARM2  = 3'd3,
        S_CORE2 = 3'd4
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            done_d_reg;
    logic            done_arm_reg;
    logic            done_arm2_reg;
    logic            busy_reg;
    logic            err_reg;
    logic [DW-1:0]   mac_q_reg;
    logic [DW-1:0]   h_rdata_reg;
    logic [DW-1:0]   q_reg;

    logic [DW-1:0]   mem [DEPTH];

    logic            host_own;
    logic            mem_we;
    logic            host_re;
    logic            core_re;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            timeout_hit;
    logic            done_rise;

    assign h_rdata   = h_rdata_reg;
    assign q         = q_reg;
    assign done_arm  = done_arm_reg;
    assign done_arm2 = done_arm2_reg;
    assign busy      = busy_reg;
    assign mac_q     = mac_q_reg;
    assign err       = err_reg;

    // Ownership mux: one address/data path into the buffer, selected by who owns it.
    always_comb begin
        host_own    = (state_reg == S_HOST);
        host_re     = host_own & h_sel & ~h_we;
        core_re     = ~host_own & en_memory & en_r;
        mem_we      = host_own ? (h_sel & h_we) : (en_memory & en_w);
        mem_addr    = host_own ? h_addr : addr;
        mem_wdata   = host_own ? h_wdata : d;
        timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
        done_rise   = done & ~done_d_reg;
    end

    // Buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Shared registered read port; the result lands in the owner's output register,
    // and a simultaneous core write yields the old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_rdata_reg <= '0;
            q_reg       <= '0;
        end else begin
            if (host_re) begin
                h_rdata_reg <= mem[mem_addr];
            end
            if (core_re) begin
                q_reg <= mem[mem_addr];
            end
        end
    end

    // Phase FSM with registered handshake, busy, error and MAC outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_HOST;
            cnt_reg       <= '0;
            done_d_reg    <= 1'b0;
            done_arm_reg  <= 1'b0;
            done_arm2_reg <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mac_q_reg     <= '0;
        end else begin
            done_d_reg <= done;
            if (state_reg == S_HOST) begin
                if (h_start) begin
                    state_reg    <= S_ARM1;
                    done_arm_reg <= 1'b1;
                    busy_reg     <= 1'b1;
                    err_reg      <= 1'b0;
                    cnt_reg      <= '0;
                end else if (h_start2) begin
                    state_reg     <= S_ARM2;
                    done_arm2_reg <= 1'b1;
                    busy_reg      <= 1'b1;
                    cnt_reg       <= '0;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                // Host traffic or start requests while the core owns the buffer are errors.
                if (h_sel || h_start || h_start2) begin
                    err_reg <= 1'b1;
                end
                // A real exit on the same cycle as the timeout wins over the abort.
                if (state_reg == S_ARM1 && en_memory) begin
                    state_reg    <= S_CORE1;
                    done_arm_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else if (state_reg == S_CORE1 && done_rise) begin
                    state_reg <= S_HOST;
                    mac_q_reg <= MAC;
                    busy_reg  <= 1'b0;
                end else if (state_reg == S_ARM2 && done2) begin
                    state_reg     <= S_CORE2;
                    done_arm2_reg <= 1'b0;
                    cnt_reg       <= '0;
                end else if (state_reg == S_CORE2 && done2) begin
                    state_reg <= S_HOST;
                    busy_reg  <= 1'b0;
                end else if (timeout_hit) begin
                    state_reg     <= S_HOST;
                    done_arm_reg  <= 1'b0;
                    done_arm2_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    err_reg       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcm_mem_arbiter.sv
// Directed bench for gcm_mem_arbiter. Stimulus pushes expected values into a
// scoreboard queue; a monitor drains and compares it on every falling clock edge.
module tb_gcm_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_sel, h_we, h_start, h_start2;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic [DW-1:0] h_rdata;
    logic          en_memory, en_r, en_w;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic          done, done2;
    logic [DW-1:0] MAC;
    logic          done_arm, done_arm2, busy, err;
    logic [DW-1:0] mac_q;

    gcm_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .h_sel(h_sel), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_start(h_start), .h_start2(h_start2),
        .en_memory(en_memory), .en_r(en_r), .en_w(en_w), .addr(addr), .d(d),
        .q(q), .done(done), .done2(done2), .MAC(MAC),
        .done_arm(done_arm), .done_arm2(done_arm2), .busy(busy),
        .mac_q(mac_q), .err(err)
    );

    always #5 clk = ~clk;

    typedef enum int {SIG_HRD, SIG_Q, SIG_MAC, SIG_BUSY, SIG_ERR, SIG_ARM, SIG_ARM2} sig_e;
    typedef struct {
        sig_e          sig;
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t mon_e;
    logic [DW-1:0] mon_act;

    function automatic logic [DW-1:0] peek(sig_e s);
        case (s)
            SIG_HRD:  return h_rdata;
            SIG_Q:    return q;
            SIG_MAC:  return mac_q;
            SIG_BUSY: return {{(DW-1){1'b0}}, busy};
            SIG_ERR:  return {{(DW-1){1'b0}}, err};
            SIG_ARM:  return {{(DW-1){1'b0}}, done_arm};
            default:  return {{(DW-1){1'b0}}, done_arm2};
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                mon_e   = sb.pop_front();
                mon_act = peek(mon_e.sig);
                n_tests++;
                if (mon_act !== mon_e.val) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.val);
                end else begin
                    $display("[TB] ok   %s = %h", mon_e.name, mon_act);
                end
            end
        end
    end

    task automatic expect_sig(input sig_e s, input logic [DW-1:0] v, input string name);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // One clock: returns 1 time unit after the rising edge so inputs change away from it.
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
        h_sel = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = v;
        cyc();
        h_sel = 1'b0; h_we = 1'b0;
    endtask

    task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] v, input string name);
        h_sel = 1'b1; h_we = 1'b0; h_addr = a;
        cyc();
        h_sel = 1'b0;
        expect_sig(SIG_HRD, v, name);
    endtask

    task automatic core_req(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] v);
        en_memory = 1'b1; en_r = r; en_w = w; addr = a; d = v;
        cyc();
        en_memory = 1'b0; en_r = 1'b0; en_w = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; h_sel = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        h_start = 0; h_start2 = 0; en_memory = 0; en_r = 0; en_w = 0;
        addr = '0; d = '0; done = 0; done2 = 0; MAC = '0;

        // Reset
        cyc(3);
        expect_sig(SIG_BUSY, 16'h0, "reset busy");
        expect_sig(SIG_ARM,  16'h0, "reset done_arm");
        expect_sig(SIG_ARM2, 16'h0, "reset done_arm2");
        expect_sig(SIG_MAC,  16'h0, "reset mac_q");
        expect_sig(SIG_Q,    16'h0, "reset q");
        expect_sig(SIG_ERR,  16'h0, "reset err");
        expect_sig(SIG_HRD,  16'h0, "reset h_rdata");
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL direct reset busy: got %b, expected 0", busy);
        end else begin
            $display("[TB] ok   direct reset busy = %b", busy);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL direct reset err: got %b, expected 0", err);
        end else begin
            $display("[TB] ok   direct reset err = %b", err);
        end
        rst = 1'b1;
        cyc();

        // Host write / read, including the top address
        host_wr(6'd5,  16'h1234);
        host_wr(6'd63, 16'hBEEF);
        host_rd(6'd5,  16'h1234, "host rd @5");
        host_rd(6'd63, 16'hBEEF, "host rd @63");
        host_wr(6'd0,  16'hAAAA);

        // Phase 1: done_arm held as a level until the core acknowledges
        h_start = 1'b1;
        cyc();
        h_start = 1'b0;
        expect_sig(SIG_ARM,  16'h1, "p1 done_arm set");
        expect_sig(SIG_BUSY, 16'h1, "p1 busy");
        cyc(8);
        expect_sig(SIG_ARM,  16'h1, "p1 done_arm held");
        core_req(1'b1, 1'b0, 6'd0, 16'h0);
        expect_sig(SIG_ARM,  16'h0, "p1 done_arm drop");
        expect_sig(SIG_Q,    16'hAAAA, "p1 core rd @0");
        expect_sig(SIG_BUSY, 16'h1, "p1 busy core");

        // Contention: host write ignored, err raised
        host_wr(6'd0, 16'hFFFF);
        expect_sig(SIG_ERR, 16'h1, "contention err");
        core_req(1'b1, 1'b0, 6'd0, 16'h0);
        expect_sig(SIG_Q, 16'hAAAA, "contention mem[0] kept");

        // Core writes (repeated) and read-before-write
        core_req(1'b0, 1'b1, 6'd16, 16'h5555);
        core_req(1'b0, 1'b1, 6'd16, 16'h5555);
        core_req(1'b0, 1'b1, 6'd17, 16'h1111);
        core_req(1'b1, 1'b1, 6'd17, 16'h2222);
        expect_sig(SIG_Q, 16'h1111, "rbw old data");

        // Completion: done rising edge captures MAC
        done = 1'b1; MAC = 16'hC0DE;
        cyc();
        done = 1'b0; MAC = 16'h0;
        expect_sig(SIG_MAC,  16'hC0DE, "p1 mac_q");
        expect_sig(SIG_BUSY, 16'h0, "p1 busy clear");
        expect_sig(SIG_ERR,  16'h1, "err sticky");
        n_tests++;
        if (mac_q !== 16'hC0DE) begin
            n_fail++;
            $display("[TB] FAIL direct p1 mac_q: got %h, expected c0de", mac_q);
        end else begin
            $display("[TB] ok   direct p1 mac_q = %h", mac_q);
        end
        host_rd(6'd16, 16'h5555, "host rd @16");
        host_rd(6'd17, 16'h2222, "host rd @17");
        host_rd(6'd0,  16'hAAAA, "host rd @0");
        core_req(1'b1, 1'b0, 6'd16, 16'h0);
        expect_sig(SIG_Q, 16'h1111, "core rd ignored in host");

        // Timeout: no acknowledge for 20 clk
        h_start = 1'b1;
        cyc();
        h_start = 1'b0;
        expect_sig(SIG_ERR, 16'h0, "h_start clears err");
        cyc(19);
        expect_sig(SIG_ARM, 16'h1, "to done_arm at 19");
        cyc();
        expect_sig(SIG_ARM,  16'h0, "to done_arm drop");
        expect_sig(SIG_BUSY, 16'h0, "to busy");
        expect_sig(SIG_ERR,  16'h1, "to err");
        expect_sig(SIG_MAC,  16'hC0DE, "to mac_q kept");
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL direct to err: got %b, expected 1", err);
        end else begin
            $display("[TB] ok   direct to err = %b", err);
        end

        // Reset during S_CORE1; host write in the start cycle still lands
        h_start = 1'b1; h_sel = 1'b1; h_we = 1'b1; h_addr = 6'd40; h_wdata = 16'h4040;
        cyc();
        h_start = 1'b0; h_sel = 1'b0; h_we = 1'b0;
        core_req(1'b1, 1'b0, 6'd16, 16'h0);
        expect_sig(SIG_Q, 16'h5555, "rs core rd @16");
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        expect_sig(SIG_BUSY, 16'h0, "rs busy");
        expect_sig(SIG_MAC,  16'h0, "rs mac_q");
        expect_sig(SIG_Q,    16'h0, "rs q");
        expect_sig(SIG_ERR,  16'h0, "rs err");
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL direct rs busy: got %b, expected 0", busy);
        end else begin
            $display("[TB] ok   direct rs busy = %b", busy);
        end
        host_rd(6'd16, 16'h5555, "rs data @16");
        host_rd(6'd63, 16'hBEEF, "rs data @63");
        host_rd(6'd40, 16'h4040, "start-cycle write @40");

        // Phase 2: done_arm2 held until done2; stray h_start flags err
        h_start2 = 1'b1;
        cyc();
        h_start2 = 1'b0;
        expect_sig(SIG_ARM2, 16'h1, "p2 done_arm2 set");
        expect_sig(SIG_ERR,  16'h0, "p2 err unchanged");
        n_tests++;
        if (done_arm2 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL direct p2 done_arm2: got %b, expected 1", done_arm2);
        end else begin
            $display("[TB] ok   direct p2 done_arm2 = %b", done_arm2);
        end
        cyc(3);
        h_start = 1'b1;
        cyc();
        h_start = 1'b0;
        expect_sig(SIG_ERR,  16'h1, "p2 stray start err");
        expect_sig(SIG_ARM,  16'h0, "p2 stray start ignored");
        expect_sig(SIG_ARM2, 16'h1, "p2 done_arm2 held");
        done2 = 1'b1;
        cyc();
        expect_sig(SIG_ARM2, 16'h0, "p2 done_arm2 drop");
        expect_sig(SIG_BUSY, 16'h1, "p2 busy core2");
        cyc();
        done2 = 1'b0;
        expect_sig(SIG_BUSY, 16'h0, "p2 busy clear");

        cyc(2);
        if (n_fail != 0) begin
            $display("[TB] FAIL summary: got %0d failures, expected 0", n_fail);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
